// File: rtl/deca_scan_ctrl.sv
// deca_scan_ctrl
//   Scheduler for a bank of DIGITS decade 7-segment cells. It makes the bank
//   behave as one multi-digit BCD up/down counter. It also loads digits
//   serially, LSD first, and drives the one-hot display scan strobe. A mirror
//   of every digit value is kept locally, so carry and borrow decisions never
//   need feedback from the cells.
//
// Ports
//   clk        system clock, rising edge
//   clr        synchronous active-high reset
//   cmd        00 stop, 01 run up, 10 run down, 11 load (qualified by cmd_valid)
//   cmd_valid  command strobe
//   ld_data    BCD digit to load, LSD first
//   ld_valid   ld_data valid
//   ld_ready   controller accepts ld_data this cycle (high throughout LOAD)
//   ctl_o      per-digit cell command, digit k at [2k+1:2k]:
//              00 down, 01 up, 10 hold, 11 load
//   e_o        shared load bus to the cells
//   an_o       one-hot scan strobe
//   bcd_o      mirror of the digit values, digit k at [4k+3:4k]
//   tc         one-cycle pulse on terminal count
//   busy       high in any state except IDLE
//   err        sticky flag: a load digit greater than 9 was received
module deca_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int SCAN_DIV = 1000,
  parameter int WRAP     = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [1:0]            cmd,
  input  logic                  cmd_valid,
  input  logic [3:0]            ld_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  output logic [2*DIGITS-1:0]   ctl_o,
  output logic [3:0]            e_o,
  output logic [DIGITS-1:0]     an_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  tc,
  output logic                  busy,
  output logic                  err
);

  localparam int PW = $clog2(PRESCALE);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [2*DIGITS-1:0] HOLD_ALL = {DIGITS{2'b10}};

  typedef enum logic [1:0] {IDLE, UP, DOWN, LOAD} state_t;

  state_t                state_reg;
  logic [PW-1:0]         presc_reg;
  logic [SW-1:0]         scan_reg;
  logic [IW-1:0]         idx_reg;
  logic [2*DIGITS-1:0]   ctl_reg;
  logic [3:0]            e_reg;
  logic [DIGITS-1:0]     an_reg;
  logic [4*DIGITS-1:0]   bcd_reg;
  logic                  tc_reg;
  logic                  ld_ready_reg;
  logic                  err_reg;

  // Candidate next commands and mirror values for each kind of event.
  logic [DIGITS-1:0]     is9, is0, up_en, dn_en;
  logic [2*DIGITS-1:0]   up_ctl, dn_ctl, ld_ctl;
  logic [4*DIGITS-1:0]   up_bcd, dn_bcd, ld_bcd;
  logic [3:0]            ld_val;
  logic                  tick, all9, all0, run_up, run_cmd, term;

  assign ld_val  = (ld_data > 4'd9) ? 4'd0 : ld_data;
  assign tick    = (presc_reg == PRESC_LAST);
  assign all9    = &is9;
  assign all0    = &is0;
  // A run command coinciding with a tick picks the direction of that tick.
  assign run_cmd = cmd_valid && ((cmd == 2'b01) || (cmd == 2'b10));
  assign run_up  = run_cmd ? (cmd == 2'b01) : (state_reg == UP);
  assign term    = run_up ? all9 : all0;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      logic       sel;
      assign d       = bcd_reg[4*gi +: 4];
      assign sel     = (idx_reg == IW'(gi));
      assign is9[gi] = (d == 4'd9);
      assign is0[gi] = (d == 4'd0);
      // Digit k moves only when every lower digit is at its rollover value.
      if (gi == 0) begin : g_lsd
        assign up_en[gi] = 1'b1;
        assign dn_en[gi] = 1'b1;
      end else begin : g_upper
        assign up_en[gi] = &is9[gi-1:0];
        assign dn_en[gi] = &is0[gi-1:0];
      end
      assign up_ctl[2*gi +: 2] = up_en[gi] ? 2'b01 : 2'b10;
      assign dn_ctl[2*gi +: 2] = dn_en[gi] ? 2'b00 : 2'b10;
      assign ld_ctl[2*gi +: 2] = sel ? 2'b11 : 2'b10;
      assign up_bcd[4*gi +: 4] = up_en[gi] ? (is9[gi] ? 4'd0 : d + 4'd1) : d;
      assign dn_bcd[4*gi +: 4] = dn_en[gi] ? (is0[gi] ? 4'd9 : d - 4'd1) : d;
      assign ld_bcd[4*gi +: 4] = sel ? ld_val : d;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg    <= IDLE;
      presc_reg    <= '0;
      scan_reg     <= '0;
      idx_reg      <= '0;
      ctl_reg      <= HOLD_ALL;
      e_reg        <= 4'd0;
      an_reg       <= DIGITS'(1);
      bcd_reg      <= '0;
      tc_reg       <= 1'b0;
      ld_ready_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      // Cell commands and tc are single-cycle; hold is the resting command.
      ctl_reg <= HOLD_ALL;
      tc_reg  <= 1'b0;

      if (scan_reg == SCAN_LAST) begin
        scan_reg <= '0;
        an_reg   <= {an_reg[DIGITS-2:0], an_reg[DIGITS-1]};
      end else begin
        scan_reg <= scan_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          presc_reg <= '0;
          if (cmd_valid) begin
            case (cmd)
              2'b01:   state_reg <= UP;
              2'b10:   state_reg <= DOWN;
              2'b11: begin
                state_reg    <= LOAD;
                ld_ready_reg <= 1'b1;
                idx_reg      <= '0;
              end
              default: state_reg <= IDLE;
            endcase
          end
        end

        UP, DOWN: begin
          if (cmd_valid && (cmd == 2'b00)) begin
            state_reg <= IDLE;
            presc_reg <= '0;
          end else if (cmd_valid && (cmd == 2'b11)) begin
            state_reg    <= LOAD;
            presc_reg    <= '0;
            ld_ready_reg <= 1'b1;
            idx_reg      <= '0;
          end else begin
            state_reg <= run_up ? UP : DOWN;
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
              tc_reg <= term;
              if (term && (WRAP == 0)) begin
                state_reg <= IDLE;
              end else begin
                ctl_reg <= run_up ? up_ctl : dn_ctl;
                bcd_reg <= run_up ? up_bcd : dn_bcd;
              end
            end
          end
        end

        LOAD: begin
          if (ld_valid && ld_ready_reg) begin
            e_reg   <= ld_val;
            ctl_reg <= ld_ctl;
            bcd_reg <= ld_bcd;
            if (ld_data > 4'd9) begin
              err_reg <= 1'b1;
            end
            if (idx_reg == IDX_LAST) begin
              state_reg    <= IDLE;
              ld_ready_reg <= 1'b0;
              idx_reg      <= '0;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ld_ready = ld_ready_reg;
  assign ctl_o    = ctl_reg;
  assign e_o      = e_reg;
  assign an_o     = an_reg;
  assign bcd_o    = bcd_reg;
  assign tc       = tc_reg;
  assign busy     = (state_reg != IDLE);
  assign err      = err_reg;

endmodule
